// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port RAM between an instruction requester and a data
//   requester. The arbiter picks one winner while idle and holds that winner
//   until the memory grants it. A small owner FIFO records which port each
//   granted transaction belongs to, so that read responses can be routed back
//   in grant order.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration (the port granted last gets lowest
//                priority next; the pointer moves only on a grant)
//   undefined -> fixed priority, the data port always beats the instruction port
//
// Parameter
//   MAX_OUTSTANDING (1..4) : granted-but-unanswered memory transactions allowed
//
// Ports
//   clk_i, rst_i                          clock, synchronous active-high reset
//   instr_req_i/gnt_o/rvalid_o            instruction handshake
//   instr_addr_i, instr_rdata_o           instruction address / read data
//   data_req_i/gnt_o/rvalid_o             data handshake
//   data_addr_i/we_i/be_i/wdata_i         data payload
//   data_rdata_o                          data read data
//   mem_req_o/gnt_i/rvalid_i              shared RAM handshake
//   mem_addr_o/we_o/be_o/wdata_o          RAM payload, mem_rdata_i RAM read data
//   protocol_err_o                        sticky: response seen with nothing outstanding
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        protocol_err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_GNT = 1'b1;

  // Owner encoding stored in the FIFO
  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic             owner_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic win_s;
  logic cur_sel_s;
  logic full_s;
  logic empty_s;
  logic mem_req_s;
  logic push_s;
  logic pop_s;
  logic head_s;

  // Advance a FIFO pointer with wrap at the configured depth
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data port has priority on a tie, 0 = instruction port has priority
  logic prio_q, prio_d;

  // Round-robin winner selection among the asserted requests
  always_comb begin
    win_s = OWN_DATA;
    if (data_req_i && instr_req_i) begin
      win_s = prio_q ? OWN_DATA : OWN_INSTR;
    end else if (data_req_i) begin
      win_s = OWN_DATA;
    end else begin
      win_s = OWN_INSTR;
    end
  end

  // The port just granted drops to lowest priority
  always_comb begin
    prio_d = prio_q;
    if (push_s) begin
      prio_d = (cur_sel_s == OWN_INSTR);
    end else begin
      prio_d = prio_q;
    end
  end

  // Round-robin pointer register, data-first out of reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b1;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  // Fixed-priority winner selection: data beats instruction
  always_comb begin
    win_s = OWN_DATA;
    if (data_req_i) begin
      win_s = OWN_DATA;
    end else begin
      win_s = OWN_INSTR;
    end
  end
`endif

  // Request generation; while waiting for a grant the latched winner is frozen
  always_comb begin
    cur_sel_s = (state_q == ST_WAIT_GNT) ? sel_q : win_s;
    full_s    = (count_q == CNT_W'(MAX_OUTSTANDING));
    empty_s   = (count_q == CNT_W'(0));
    if (rst_i) begin
      mem_req_s = 1'b0;
    end else if (state_q == ST_WAIT_GNT) begin
      mem_req_s = 1'b1;
    end else if ((instr_req_i || data_req_i) && !full_s) begin
      mem_req_s = 1'b1;
    end else begin
      mem_req_s = 1'b0;
    end
    push_s = mem_req_s & mem_gnt_i;
    // A response with nothing outstanding is a protocol error, never a pop
    pop_s  = ~rst_i & mem_rvalid_i & ~empty_s;
    head_s = owner_q[rd_ptr_q];
  end

  // Output mux: payload of the selected port, zero when no request is issued
  always_comb begin
    mem_req_o      = mem_req_s;
    mem_addr_o     = 32'h0000_0000;
    mem_we_o       = 1'b0;
    mem_be_o       = 4'h0;
    mem_wdata_o    = 32'h0000_0000;
    instr_gnt_o    = push_s & (cur_sel_s == OWN_INSTR);
    data_gnt_o     = push_s & (cur_sel_s == OWN_DATA);
    instr_rvalid_o = pop_s & (head_s == OWN_INSTR);
    data_rvalid_o  = pop_s & (head_s == OWN_DATA);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    protocol_err_o = err_q;
    if (!mem_req_s) begin
      mem_addr_o = 32'h0000_0000;
    end else if (cur_sel_s == OWN_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      // Instruction fetches are always full-word reads
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_wdata_o = 32'h0000_0000;
    end
  end

  // FSM next state: latch the winner when the memory stalls the request
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_s && !mem_gnt_i) begin
          state_d = ST_WAIT_GNT;
          sel_d   = win_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_GNT: begin
        if (mem_gnt_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_GNT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Owner FIFO pointer/count bookkeeping and the sticky error flag
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    case ({push_s, pop_s})
      2'b10: begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        count_d  = count_q + CNT_W'(1);
      end
      2'b01: begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d  = count_q - CNT_W'(1);
      end
      2'b11: begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      default: begin
        count_d = count_q;
      end
    endcase
    err_d = err_q | (mem_rvalid_i & empty_s);
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      sel_q    <= OWN_DATA;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        owner_q[i] <= OWN_INSTR;
      end
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      if (push_s) begin
        owner_q[wr_ptr_q] <= cur_sel_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        protocol_err_o;

  int n_pass  = 0;
  int n_total = 0;
  logic exp_d;

  mem_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0; instr_addr_i = 32'h0;
    data_req_i   = 1'b0; data_addr_i  = 32'h0; data_we_i = 1'b0;
    data_be_i    = 4'h0; data_wdata_i = 32'h0;
    mem_gnt_i    = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
  endtask

  // Advance one clock; inputs are driven 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    tick();
    // Everything asserted while in reset: outputs must stay quiet
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    settle();
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_data_gnt", data_gnt_o, 1'b0);
    chk1("rst_instr_gnt", instr_gnt_o, 1'b0);
    chk1("rst_data_rvalid", data_rvalid_o, 1'b0);
    chk1("rst_instr_rvalid", instr_rvalid_o, 1'b0);
    tick();
    rst_i = 1'b0; idle_inputs(); settle();
    chk1("post_rst_err", protocol_err_o, 1'b0);
    chk1("idle_mem_req", mem_req_o, 1'b0);
    chk32("idle_mem_addr", mem_addr_o, 32'h0);

    // Both requesters continuously, memory grants every cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      instr_req_i = 1'b1; instr_addr_i = 32'h600;
      data_req_i  = 1'b1; data_addr_i  = 32'h700;
      mem_gnt_i = 1'b1; mem_rvalid_i = (i > 0);
      settle();
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      chk1("both_data_gnt", data_gnt_o, exp_d);
      chk1("both_instr_gnt", instr_gnt_o, ~exp_d);
    end
    tick();
    idle_inputs(); mem_rvalid_i = 1'b1; settle();
    chk1("both_last_data_rvalid", data_rvalid_o, exp_d);
    chk1("both_last_instr_rvalid", instr_rvalid_o, ~exp_d);

    // Data write, then instruction fetch while the write response returns
    tick();
    idle_inputs();
    data_req_i = 1'b1; data_addr_i = 32'h100; data_we_i = 1'b1;
    data_be_i = 4'b0011; data_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1'b1;
    settle();
    chk1("wr_mem_req", mem_req_o, 1'b1);
    chk32("wr_addr", mem_addr_o, 32'h100);
    chk1("wr_we", mem_we_o, 1'b1);
    chk32("wr_be", {28'h0, mem_be_o}, 32'h3);
    chk32("wr_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk1("wr_data_gnt", data_gnt_o, 1'b1);
    chk1("wr_instr_gnt", instr_gnt_o, 1'b0);
    tick();
    idle_inputs();
    instr_req_i = 1'b1; instr_addr_i = 32'h200; mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11112222;
    settle();
    chk32("if_addr", mem_addr_o, 32'h200);
    chk1("if_we", mem_we_o, 1'b0);
    chk32("if_be", {28'h0, mem_be_o}, 32'hF);
    chk32("if_wdata", mem_wdata_o, 32'h0);
    chk1("if_instr_gnt", instr_gnt_o, 1'b1);
    chk1("if_wr_resp_data_rvalid", data_rvalid_o, 1'b1);
    chk1("if_wr_resp_instr_rvalid", instr_rvalid_o, 1'b0);
    chk32("if_wr_resp_rdata", data_rdata_o, 32'h11112222);
    tick();
    idle_inputs(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h33334444; settle();
    chk1("if_resp_instr_rvalid", instr_rvalid_o, 1'b1);
    chk1("if_resp_data_rvalid", data_rvalid_o, 1'b0);

    // Grants I then D, responses return in that order
    tick();
    idle_inputs(); instr_req_i = 1'b1; instr_addr_i = 32'h240; mem_gnt_i = 1'b1; settle();
    chk1("ord_instr_gnt", instr_gnt_o, 1'b1);
    tick();
    idle_inputs(); data_req_i = 1'b1; data_addr_i = 32'h300; data_be_i = 4'hF;
    mem_gnt_i = 1'b1; settle();
    chk1("ord_data_gnt", data_gnt_o, 1'b1);
    tick();
    idle_inputs(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA0000; settle();
    chk1("ord_first_instr_rvalid", instr_rvalid_o, 1'b1);
    chk1("ord_first_data_rvalid", data_rvalid_o, 1'b0);
    chk32("ord_first_rdata", instr_rdata_o, 32'hAAAA0000);
    tick();
    idle_inputs(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555FFFF; settle();
    chk1("ord_second_data_rvalid", data_rvalid_o, 1'b1);
    chk1("ord_second_instr_rvalid", instr_rvalid_o, 1'b0);
    chk32("ord_second_rdata", data_rdata_o, 32'h5555FFFF);

    // Outstanding limit: two grants, stall while full, resume after a pop
    for (int c = 1; c <= 6; c++) begin
      tick();
      idle_inputs(); data_req_i = 1'b1; data_addr_i = 32'h800; mem_gnt_i = 1'b1;
      mem_rvalid_i = (c == 5);
      settle();
      chk1("lim_mem_req", mem_req_o, (c == 1) || (c == 2) || (c == 6));
      chk1("lim_data_gnt", data_gnt_o, (c == 1) || (c == 2) || (c == 6));
      chk1("lim_data_rvalid", data_rvalid_o, (c == 5));
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      idle_inputs(); mem_rvalid_i = 1'b1; settle();
      chk1("lim_drain_rvalid", data_rvalid_o, 1'b1);
    end

    // Stalled data request: payload held, late instr request not arbitrated
    for (int c = 0; c < 4; c++) begin
      tick();
      idle_inputs(); data_req_i = 1'b1; data_addr_i = 32'h400;
      instr_req_i = (c >= 1); instr_addr_i = 32'h500; mem_gnt_i = (c == 3);
      settle();
      chk32("stall_addr", mem_addr_o, 32'h400);
      chk1("stall_data_gnt", data_gnt_o, (c == 3));
      chk1("stall_instr_gnt", instr_gnt_o, 1'b0);
    end
    tick();
    idle_inputs(); instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1; settle();
    chk1("stall_then_instr_gnt", instr_gnt_o, 1'b1);
    chk32("stall_then_instr_addr", mem_addr_o, 32'h500);
    tick();
    idle_inputs(); mem_rvalid_i = 1'b1; settle();
    chk1("stall_resp1_data", data_rvalid_o, 1'b1);
    tick();
    idle_inputs(); mem_rvalid_i = 1'b1; settle();
    chk1("stall_resp2_instr", instr_rvalid_o, 1'b1);

    // No requests at all
    tick();
    idle_inputs(); mem_gnt_i = 1'b1; settle();
    chk1("noreq_mem_req", mem_req_o, 1'b0);
    chk1("noreq_data_gnt", data_gnt_o, 1'b0);
    chk1("noreq_instr_gnt", instr_gnt_o, 1'b0);
    chk32("noreq_addr", mem_addr_o, 32'h0);
    chk1("noreq_err", protocol_err_o, 1'b0);

    // Reset discards an outstanding owner; the late response is a stray
    tick();
    idle_inputs(); instr_req_i = 1'b1; instr_addr_i = 32'h900; mem_gnt_i = 1'b1; settle();
    chk1("rstmid_instr_gnt", instr_gnt_o, 1'b1);
    tick();
    idle_inputs(); rst_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; settle();
    chk1("rstmid_mem_req", mem_req_o, 1'b0);
    tick();
    idle_inputs(); rst_i = 1'b0; mem_rvalid_i = 1'b1; settle();
    chk1("stray_instr_rvalid", instr_rvalid_o, 1'b0);
    chk1("stray_data_rvalid", data_rvalid_o, 1'b0);
    chk1("stray_err_not_yet", protocol_err_o, 1'b0);
    tick();
    idle_inputs(); data_req_i = 1'b1; mem_gnt_i = 1'b1; settle();
    chk1("stray_err_set", protocol_err_o, 1'b1);
    chk1("stray_count_zero_req", mem_req_o, 1'b1);
    tick();
    idle_inputs(); settle();
    chk1("stray_err_sticky", protocol_err_o, 1'b1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; settle();
    chk1("err_cleared_by_rst", protocol_err_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
